shift_add_mult_ctrl: RTL and testbench



---
 rtl/shift_add_mult_ctrl_if.sv | 25 ++
 rtl/shift_add_mult_ctrl.sv | 94 +++++++++
 tb/tb_shift_add_mult_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/shift_add_mult_ctrl_if.sv
// Handshake and data bundle between the multiplier control stage, its operand
// source and the upstream left_shift_reg.
interface shift_add_mult_ctrl_if #(
   parameter int n = 8
);
   logic             start;
   logic [n-1:0]     multiplier;
   logic [2*n-1:0]   shifted_multiplicand;
   logic             load;
   logic             en;
   logic [2*n-1:0]   product;
   logic             busy;
   logic             done;

   // start is sampled only while idle; product is qualified by the one-cycle done pulse.
   modport master (
      output start, multiplier, shifted_multiplicand,
      input  load, en, product, busy, done
   );

   modport slave (
      input  start, multiplier, shifted_multiplicand,
      output load, en, product, busy, done
   );
endinterface

// File: rtl/shift_add_mult_ctrl.sv
// Control and accumulate stage of a sequential shift-add multiplier: drives the
// upstream shifter, scans the multiplier LSB-first and accumulates a 2n-bit product.
module shift_add_mult_ctrl #(
   parameter int n = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   shift_add_mult_ctrl_if.slave bus,
   output logic [1:0]           state_dbg
);

   localparam int CW = (n > 1) ? $clog2(n) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(n - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      MUL  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [n-1:0]     mreg;
   logic [2*n-1:0]   acc;
   logic [CW-1:0]    cnt;
   logic             load_d;
   logic             en_d;
   logic             busy_d;
   logic             done_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Outputs are Moore-decoded from state only, so no input reaches an output combinationally.
   always_comb begin
      state_nxt = state;
      load_d    = 1'b0;
      en_d      = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      case (state)
         IDLE: if (bus.start) state_nxt = LOAD;
         LOAD: begin
            load_d    = 1'b1;
            busy_d    = 1'b1;
            state_nxt = MUL;
         end
         MUL: begin
            en_d   = 1'b1;
            busy_d = 1'b1;
            if (cnt == CNT_LAST) state_nxt = DONE;
         end
         DONE: begin
            done_d    = 1'b1;
            busy_d    = 1'b1;
            state_nxt = IDLE;
         end
      endcase
   end

   // Always n accumulate edges, even when mreg runs out of ones early.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc  <= '0;
         mreg <= '0;
         cnt  <= '0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               mreg <= bus.multiplier;
               acc  <= '0;
               cnt  <= '0;
            end
            MUL: begin
               if (mreg[0]) acc <= acc + bus.shifted_multiplicand;
               mreg <= mreg >> 1;
               cnt  <= cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

   assign bus.load    = load_d;
   assign bus.en      = en_d;
   assign bus.busy    = busy_d;
   assign bus.done    = done_d;
   assign bus.product = acc;
   assign state_dbg   = state;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Bench for shift_add_mult_ctrl: n=8 and n=4 instances chained with a behavioural
// left_shift_reg, a cycle-schedule reference model and literal product checks.
module tb_shift_add_mult_ctrl;
   localparam int N  = 8;
   localparam int N4 = 4;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   shift_add_mult_ctrl_if #(.n(N))  bus8 ();
   shift_add_mult_ctrl_if #(.n(N4)) bus4 ();
   logic [1:0]      dbg8;
   logic [1:0]      dbg4;
   logic [N-1:0]    mcand8 = '0;
   logic [N4-1:0]   mcand4 = '0;
   logic [2*N-1:0]  sreg8  = '0;
   logic [2*N4-1:0] sreg4  = '0;

   // Upstream left_shift_reg (not reset, as in the system)
   always @(posedge clk) begin
      if (bus8.load)    sreg8 <= {{N{1'b0}}, mcand8};
      else if (bus8.en) sreg8 <= sreg8 << 1;
      if (bus4.load)    sreg4 <= {{N4{1'b0}}, mcand4};
      else if (bus4.en) sreg4 <= sreg4 << 1;
   end
   assign bus8.shifted_multiplicand = sreg8;
   assign bus4.shifted_multiplicand = sreg4;

   shift_add_mult_ctrl #(.n(N)) dut8 (
      .clk(clk), .rst_n(rst_n), .bus(bus8), .state_dbg(dbg8)
   );
   shift_add_mult_ctrl #(.n(N4)) dut4 (
      .clk(clk), .rst_n(rst_n), .bus(bus4), .state_dbg(dbg4)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (n=8) ----------------
   // since8 = cycles elapsed after the accepting edge (-1 when idle).
   int              since8 = -1;
   logic [N-1:0]    ma8    = '0;
   logic [N-1:0]    mb8    = '0;
   logic [2*N-1:0]  held8  = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         since8 <= -1;
         held8  <= '0;
      end else if (since8 < 0) begin
         if (bus8.start) begin
            since8 <= 0;
            ma8    <= bus8.multiplier;
            held8  <= '0;
         end
      end else if (since8 == 0) begin
         mb8    <= mcand8;
         since8 <= 1;
      end else if (since8 == N + 1) begin
         since8 <= -1;
      end else begin
         if (since8 == N) held8 <= (2*N)'(ma8) * (2*N)'(mb8);
         since8 <= since8 + 1;
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      chk("load", 32'(bus8.load), 32'(since8 == 0));
      chk("en",   32'(bus8.en),   32'(since8 >= 1 && since8 <= N));
      chk("busy", 32'(bus8.busy), 32'(since8 >= 0));
      chk("done", 32'(bus8.done), 32'(since8 == N + 1));
      if (since8 <= 0 || since8 == N + 1)
         chk("product", 32'(bus8.product), 32'(held8));
   end

   // ---------------- driver tasks ----------------
   // Launch one multiply from IDLE; optionally re-pulse start in MUL and in DONE.
   task automatic mul8(input logic [N-1:0] a, input logic [N-1:0] b, input bit repulse);
      int lat;
      @(negedge clk);
      bus8.multiplier = a;
      mcand8          = b;
      bus8.start      = 1'b1;
      @(posedge clk);
      #1 bus8.start = 1'b0;
      for (lat = 1; lat <= 40; lat++) begin
         @(posedge clk);
         #1 bus8.start = repulse && (lat == 4 || lat == N + 1);
         if (bus8.done) break;
      end
      chk("latency8", 32'(lat), 32'(N + 1));
      @(posedge clk);
      #1 bus8.start = 1'b0;
   endtask

   task automatic mul4(input logic [N4-1:0] a, input logic [N4-1:0] b);
      int lat;
      @(negedge clk);
      bus4.multiplier = a;
      mcand4          = b;
      bus4.start      = 1'b1;
      @(posedge clk);
      #1 bus4.start = 1'b0;
      for (lat = 1; lat <= 40; lat++) begin
         @(posedge clk);
         #1;
         if (bus4.done) break;
      end
      chk("latency4", 32'(lat), 32'(N4 + 1));
      @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int done_at[$];
      logic [N-1:0] a;
      logic [N-1:0] b;
      bus8.start = 1'b0;
      bus8.multiplier = '0;
      bus4.start = 1'b0;
      bus4.multiplier = '0;

      #2;
      chk("rst_load",    32'(bus8.load),    0);
      chk("rst_en",      32'(bus8.en),      0);
      chk("rst_busy",    32'(bus8.busy),    0);
      chk("rst_done",    32'(bus8.done),    0);
      chk("rst_product", 32'(bus8.product), 0);
      chk("rst_busy4",   32'(bus4.busy),    0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      mul8(8'd13, 8'd11, 1'b0);
      chk("p_13x11", 32'(bus8.product), 32'd143);
      repeat (3) @(negedge clk);
      chk("p_13x11_held", 32'(bus8.product), 32'd143);

      mul8(8'd255, 8'd255, 1'b0);
      chk("p_255x255", 32'(bus8.product), 32'd65025);
      mul8(8'd0, 8'd200, 1'b0);
      chk("p_0x200", 32'(bus8.product), 32'd0);
      mul8(8'd200, 8'd0, 1'b0);
      chk("p_200x0", 32'(bus8.product), 32'd0);

      mul8(8'd21, 8'd9, 1'b1);
      chk("p_repulse", 32'(bus8.product), 32'd189);

      // start held high: back-to-back launches
      @(negedge clk);
      bus8.multiplier = 8'd5;
      mcand8          = 8'd17;
      bus8.start      = 1'b1;
      for (int c = 1; c <= 80; c++) begin
         @(posedge clk);
         #1;
         if (bus8.done) done_at.push_back(c);
         if (done_at.size() == 3) break;
      end
      bus8.start = 1'b0;
      chk("held_count", 32'(done_at.size()), 3);
      if (done_at.size() == 3) begin
         chk("held_gap1", 32'(done_at[1] - done_at[0]), 32'(N + 3));
         chk("held_gap2", 32'(done_at[2] - done_at[1]), 32'(N + 3));
      end
      chk("p_held", 32'(bus8.product), 32'd85);
      repeat (2) @(posedge clk);

      // asynchronous reset on the 4th MUL cycle of 100x3
      @(negedge clk);
      bus8.multiplier = 8'd100;
      mcand8          = 8'd3;
      bus8.start      = 1'b1;
      @(posedge clk);
      #1 bus8.start = 1'b0;
      repeat (4) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("abort_load",    32'(bus8.load),    0);
      chk("abort_en",      32'(bus8.en),      0);
      chk("abort_busy",    32'(bus8.busy),    0);
      chk("abort_done",    32'(bus8.done),    0);
      chk("abort_product", 32'(bus8.product), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      mul8(8'd7, 8'd6, 1'b0);
      chk("p_7x6", 32'(bus8.product), 32'd42);

      mul4(4'd15, 4'd15);
      chk("p4_15x15", 32'(bus4.product), 32'd225);
      mul4(4'd9, 4'd5);
      chk("p4_9x5", 32'(bus4.product), 32'd45);

      for (int i = 0; i < 1000; i++) begin
         a = N'($urandom_range(0, 255));
         b = N'($urandom_range(0, 255));
         mul8(a, b, $urandom_range(0, 3) == 0);
         chk("p_random", 32'(bus8.product), 32'(a) * 32'(b));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
